// File: rtl/dac_chan_sched_if.sv
// rtl/dac_chan_sched_if.sv - register-write port and serial DAC word-engine handshake for dac_chan_sched
interface dac_chan_sched_if #(
    parameter int NCH = 8,
    parameter int DW  = 16,
    parameter int TW  = 6
);
    logic                    ch_wr;
    logic [$clog2(NCH)-1:0]  ch_addr;
    logic [DW-1:0]           ch_data;
    logic [TW-1:0]           ch_tm;
    logic                    busybee;
    logic [DW-1:0]           vin;
    logic [TW-1:0]           tm;
    logic                    nw;

    modport master (
        input  ch_wr, ch_addr, ch_data, ch_tm, busybee,
        output vin, tm, nw
    );

    modport slave (
        output ch_wr, ch_addr, ch_data, ch_tm, busybee,
        input  vin, tm, nw
    );
endinterface

// File: rtl/dac_chan_sched.sv
// rtl/dac_chan_sched.sv - round-robin channel scheduler for one serial DAC word engine
// Optional fixed priority for channel 0 when DAC_CHAN_SCHED_PRIO0_EN is defined.
module dac_chan_sched #(
    parameter int NCH    = 8,
    parameter int DW     = 16,
    parameter int TW     = 6,
    parameter int ACK_TO = 40
) (
    input  logic                   bitclk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   err_clr,
    dac_chan_sched_if.master       bus,
    output logic [$clog2(NCH)-1:0] cur_ch,
    output logic [NCH-1:0]         pending,
    output logic                   ack_err
);
    localparam int AW = $clog2(NCH);
    localparam int CW = $clog2(ACK_TO + 1);

    typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

    state_t              state_q, state_d;
    logic [DW+TW-1:0]    regs [NCH];
    logic [AW-1:0]       ptr_q;
    logic [CW-1:0]       cnt_q;
    logic [AW-1:0]       nxt_ch;
    logic                nxt_found;
    logic [NCH-1:0]      pend_d;
    logic                issue, accept, timeout;

    // First pending channel after the last served one, wrapping NCH-1 -> 0.
    always_comb begin
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = 1; i <= NCH; i++) begin
            if (!nxt_found && pending[ptr_q + AW'(i)]) begin
                nxt_found = 1'b1;
                nxt_ch    = ptr_q + AW'(i);
            end
        end
`ifdef DAC_CHAN_SCHED_PRIO0_EN
        if (pending[0]) begin
            nxt_ch = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        accept  = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && (|pending)) begin
                    issue   = 1'b1;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.busybee) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end else if (cnt_q <= CW'(1)) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Issuing on the falling edge of busybee keeps nw high for the engine's end-of-word decision.
                if (!bus.busybee) begin
                    if (enable && (|pending)) begin
                        issue   = 1'b1;
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A write in the same cycle as an issue or timeout wins, so the newest value is always sent later.
    always_comb begin
        pend_d = pending;
        if (issue) begin
            pend_d[nxt_ch] = 1'b0;
        end
        if (timeout) begin
            pend_d[cur_ch] = 1'b1;
        end
        if (bus.ch_wr) begin
            pend_d[bus.ch_addr] = 1'b1;
        end
    end

    always_ff @(posedge bitclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pending <= '0;
            ptr_q   <= AW'(NCH - 1);
            cur_ch  <= '0;
            cnt_q   <= '0;
            ack_err <= 1'b0;
            bus.vin <= '0;
            bus.tm  <= '0;
            bus.nw  <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pending <= pend_d;
            if (bus.ch_wr) begin
                regs[bus.ch_addr] <= {bus.ch_data, bus.ch_tm};
            end
            if (issue) begin
                {bus.vin, bus.tm} <= regs[nxt_ch];
                cur_ch            <= nxt_ch;
                bus.nw            <= 1'b1;
                cnt_q             <= CW'(ACK_TO);
            end else if (accept || timeout) begin
                bus.nw <= 1'b0;
            end else if (state_q == REQ) begin
                cnt_q <= cnt_q - CW'(1);
            end
`ifdef DAC_CHAN_SCHED_PRIO0_EN
            if (accept && (cur_ch != '0)) begin
                ptr_q <= cur_ch;
            end
`else
            if (accept) begin
                ptr_q <= cur_ch;
            end
`endif
            if (timeout) begin
                ack_err <= 1'b1;
            end else if (err_clr) begin
                ack_err <= 1'b0;
            end
        end
    end
endmodule

// File: doc/dac_chan_sched.md
Name: dac_chan_sched

Overview:
- Round-robin scheduler that shares the single 16-bit serial DAC word engine between NCH logical channels.
- Firmware or host logic writes per-channel setpoints and timer codes into a small register file. Each write marks that channel pending.
- The block presents one word at a time on vin/tm with an nw strobe. It tracks the engine's busybee handshake and flags engines that fail to accept a word.

Parameters:
- NCH, 8, number of channels (power of two, 2..16).
- DW, 16, setpoint width, equal to the engine vin width.
- TW, 6, timer code width, equal to the engine tm width.
- ACK_TO, 40, bitclk cycles to wait for busybee to rise after nw is asserted.

Ports:
- bitclk  in  1  engine bit clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  scheduling enable; when low, no new issue starts.
- ch_wr  in  1  register-file write strobe.
- ch_addr  in  clog2(NCH)  channel written.
- ch_data  in  DW  setpoint written.
- ch_tm  in  TW  timer code written.
- busybee  in  1  busy flag from the word engine.
- vin  out  DW  word presented to the engine.
- tm  out  TW  timer code presented to the engine.
- nw  out  1  new-word request to the engine.
- cur_ch  out  clog2(NCH)  channel currently issued.
- pending  out  NCH  per-channel pending flags.
- ack_err  out  1  sticky acceptance-timeout flag.
- err_clr  in  1  clears ack_err.

Behaviour:
- Reset (async, rst_n low):
  - vin=0, tm=0, nw=0, cur_ch=0, pending=0, ack_err=0.
  - Register file cleared to 0. Round-robin pointer set to NCH-1, so channel 0 is served first.
  - State goes to IDLE.
  - Reset mid-operation drops nw immediately. The engine finishes its word unsupervised.
- Register file write:
  - On ch_wr, regs[ch_addr] <= {ch_data, ch_tm} and pending[ch_addr] <= 1.
  - Writes to an already pending channel coalesce: the latest value wins and one transfer occurs.
- Arbiter:
  - The next channel is the first pending index after the last served, searching upward with wrap-around from NCH-1 to 0.
  - It is evaluated combinationally from the registered pending vector.
- FSM:
  - IDLE: if enable and any pending bit is set, latch vin/tm from regs[next], set cur_ch=next, clear pending[next], set nw=1, load the timeout counter with ACK_TO, and go to REQ.
    - A write to the same channel in the same cycle wins: pending stays 1 and the new value is sent in a later slot.
  - REQ: hold nw, vin and tm stable.
    - When busybee=1, drop nw, update the pointer to cur_ch, and go to BUSY.
    - If the counter reaches 0 first, drop nw, set ack_err, re-set pending[cur_ch] (retry later), and go to IDLE.
  - BUSY: wait for busybee=0.
    - If busybee falls with enable=1 and pending non-zero, issue the next channel directly in that cycle (same actions as IDLE). nw is then high when the engine samples its end-of-word decision, giving back-to-back words with no gap.
    - Otherwise go to IDLE.
- enable low while in REQ or BUSY: the current word completes normally and no new issue occurs.
- err_clr clears ack_err. If err_clr and a new timeout occur in the same cycle, the set wins.
- Latency: ch_wr to nw high is 2 cycles when the block is idle.

Optional Feature:
- Macro: DAC_CHAN_SCHED_PRIO0_EN.
- Defined: channel 0 has fixed priority. If pending[0] is set at any issue decision, channel 0 is chosen regardless of the round-robin pointer, and the pointer is not updated by channel 0 grants.
- Undefined: pure round-robin across all channels, as described above.

Test Plan:
- Single write: write ch3 = 0xA55A, tm=5, with enable=1 → nw high 2 cycles later; vin=0xA55A, tm=5, cur_ch=3. nw drops the cycle after busybee rises, and pending[3]=0.
- Fairness: write ch0, ch1 and ch7 in consecutive cycles, with an engine model serving each word → issue order 0, 1, 7. While ch0 is busy, write ch0 again → order continues 1, 7, then 0.
- Back-to-back: with ch2 and ch5 pending and a model holding busybee high for 30 cycles → nw for ch5 is asserted in the cycle busybee falls for ch2, with no IDLE cycle between them.
- Coalesce and collision: write ch4 = 0x1111, then ch4 = 0x2222 before issue → only 0x2222 is sent. A write to ch4 in the issue cycle → a second transfer of the new value follows.
- Timeout: busybee stuck at 0, write ch1 → nw stays high for 40 cycles, then drops. ack_err=1 and pending[1]=1. err_clr → ack_err=0.
- Reset mid-word: assert rst_n low during BUSY → nw, pending and ack_err are 0 at once. After release, the first issued channel is the lowest pending channel.
